// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and registered in_ready.
// Optional stall-cycle counter enabled by defining PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int CTRL_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]        in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [15:0]              stall_cnt
);
  localparam int PW = NUM_CH * DATA_W;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  state_t            state_q;
  logic [PW-1:0]     m_data_q, s_data_q;
  logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
  logic              valid_q, ready_q;
  logic              acc, dep;

  assign acc = in_valid & ready_q;
  assign dep = valid_q & out_ready;

  // valid_q/ready_q mirror the state so both handshake outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else if (flush) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_q  <= HALF;
            m_data_q <= in_data;
            m_ctrl_q <= in_ctrl;
            valid_q  <= 1'b1;
            ready_q  <= 1'b1;
          end
        end
        HALF: begin
          if (acc && dep) begin
            m_data_q <= in_data;
            m_ctrl_q <= in_ctrl;
          end else if (acc) begin
            state_q  <= FULL;
            s_data_q <= in_data;
            s_ctrl_q <= in_ctrl;
            ready_q  <= 1'b0;
          end else if (dep) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (dep) begin
            state_q  <= HALF;
            m_data_q <= s_data_q;
            m_ctrl_q <= s_ctrl_q;
            ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign in_ready  = ready_q;
  assign out_data  = m_data_q;
  // Bubbles must never carry an asserted control bit downstream.
  assign out_ctrl  = m_ctrl_q & {CTRL_W{valid_q}};

`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (valid_q && !out_ready && !flush && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= 16'h0000;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_skid;
  localparam int DW = 16;
  localparam int NC = 2;
  localparam int CW = 1;
  localparam int PW = DW * NC;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [PW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .NUM_CH(NC), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [PW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          mq[$];
  logic [PW-1:0] last_m = '0;
  int            m_stall = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock: the model is a FIFO of at most two entries.
  task automatic step(input bit do_chk);
    bit   pv, acc, dep;
    ent_t e;
    pv  = (mq.size() > 0);
    acc = in_valid && (mq.size() < 2);
    dep = pv && out_ready;
    e.d = in_data;
    e.c = in_ctrl;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      last_m  = '0;
      m_stall = 0;
    end else begin
      if (pv && !out_ready && !flush && m_stall < 65535) m_stall++;
      if (flush) mq.delete();
      else begin
        if (dep) begin
          if (do_chk) $display("xfer out data=%h ctrl=%h", mq[0].d, mq[0].c);
          void'(mq.pop_front());
        end
        if (acc) mq.push_back(e);
      end
      if (mq.size() > 0) last_m = mq[0].d;
    end
    #1;
    if (do_chk) begin
      check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      check("out_ctrl", 64'(out_ctrl), (mq.size() > 0) ? 64'(mq[0].c) : 64'd0);
      check("out_data", 64'(out_data), 64'(last_m));
`ifdef PIPE_STAGE_SKID_PERF_EN
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`else
      check("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1);
  endtask

  initial begin
    logic [PW-1:0] held;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    step(1'b1);
    step(1'b1);
    check("reset_data", 64'(out_data), 64'd0);
    check("reset_ready", 64'(in_ready), 64'd1);

    // Stream with out_ready held high
    rst_n = 1'b1; in_valid = 1'b1; in_data = {16'h1234, 16'hA5A5}; in_ctrl = 1'b1; out_ready = 1'b1;
    step(1'b1);
    check("first_data", 64'(out_data), 64'h1234A5A5);
    check("first_ctrl", 64'(out_ctrl), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      in_data = PW'(k);
      step(1'b1);
      check("stream_lane0", 64'(out_data[DW-1:0]), 64'(k));
    end
    drain();

    // Backpressure fill
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_data = PW'(k);
      step(1'b1);
    end
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_head", 64'(out_data), 64'd1);
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      check("bp_order", 64'(out_data), 64'(k));
      step(1'b1);
      if (k == 2) in_valid = 1'b0;
    end
    drain();

    // Bubble masking
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000BEEF; in_ctrl = 1'b1;
    step(1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    step(1'b1);
    check("bubble_valid", 64'(out_valid), 64'd0);
    check("bubble_ctrl", 64'(out_ctrl), 64'd0);
    check("bubble_data", 64'(out_data), 64'h0000BEEF);

    // Flush priority from FULL
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 1'b1;
    in_data = 32'h11; step(1'b1);
    in_data = 32'h22; step(1'b1);
    flush = 1'b1; out_ready = 1'b1; in_data = 32'hDEAD;
    step(1'b1);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl", 64'(out_ctrl), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("flush_gone", 64'(out_valid), 64'd0);
    end

    // Reset wins over flush
    in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h5555; in_ctrl = 1'b1;
    step(1'b1);
    in_valid = 1'b0; rst_n = 1'b0; flush = 1'b1;
    step(1'b1);
    check("rst_flush_data", 64'(out_data), 64'd0);
    check("rst_flush_valid", 64'(out_valid), 64'd0);
    check("rst_flush_cnt", 64'(stall_cnt), 64'd0);
    rst_n = 1'b1; flush = 1'b0;

    // Stall counter
    in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h77;
    step(1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1);
    flush = 1'b1;
    step(1'b1);
    flush = 1'b0;
`ifdef PIPE_STAGE_SKID_PERF_EN
    check("stall_10", 64'(stall_cnt), 64'd10);
    in_valid = 1'b1; in_data = 32'h88;
    step(1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) step(1'b0);
    step(1'b1);
    check("stall_sat", 64'(stall_cnt), 64'hFFFF);
`else
    check("stall_off", 64'(stall_cnt), 64'd0);
`endif
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      in_data   = PW'($urandom);
      in_ctrl   = CW'($urandom);
      step(1'b1);
    end
    rst_n = 1'b1; flush = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register; successor to the fixed 16-bit, two-operand stage registers between EX and MEM.
- Carries NUM_CH data lanes of DATA_W bits plus a CTRL_W control field, using a valid/ready handshake and a 2-entry skid buffer.
- Gives full throughput with a registered in_ready.
- Control bits are forced to 0 whenever the stage holds no valid entry, so bubbles never cause writes. flush squashes the stage.

Parameters:
- DATA_W, 16, width of one data lane
- NUM_CH, 2, number of data lanes
- CTRL_W, 1, width of control field (e.g. mem_write)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- flush  input  1  synchronous squash, active-high
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept; registered, equals !skid_valid
- in_data  input  NUM_CH*DATA_W  lanes; lane k at [k*DATA_W +: DATA_W]
- in_ctrl  input  CTRL_W  control field
- out_valid  output  1  main entry valid
- out_ready  input  1  downstream accepts (acts as stall_n)
- out_data  output  NUM_CH*DATA_W  main entry data
- out_ctrl  output  CTRL_W  main entry ctrl; 0 when !out_valid
- stall_cnt  output  16  stall-cycle counter (see Optional Feature)

Behaviour:
- Storage:
  - Main register M = {data, ctrl}, which drives the outputs.
  - Skid register S = {data, ctrl}.
  - State EMPTY / HALF / FULL (encodes M valid and S valid).
- Handshakes:
  - acc = in_valid & in_ready.
  - dep = out_valid & out_ready.
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
- Transitions, evaluated when rst_n=1 and flush=0:
  - EMPTY: acc -> HALF, M<=in.
  - HALF:
    - acc&dep -> HALF, M<=in.
    - acc&!dep -> FULL, S<=in.
    - !acc&dep -> EMPTY.
    - neither -> hold.
  - FULL: dep -> HALF, M<=S. Otherwise hold. acc is impossible because in_ready=0.
- Ordering: FIFO; no entry is ever reordered, duplicated or dropped except by flush.
- Latency and throughput: 1 cycle from acc in EMPTY to out_valid. Throughput 1 entry/cycle while out_ready=1.
- out_data holds M data even when !out_valid; its value is then don't-care but stable. out_ctrl is masked to 0 whenever !out_valid.
- flush:
  - Next state EMPTY.
  - Data registers are not cleared.
  - Takes priority over acc/dep in the same cycle; an entry presented with flush is dropped.
  - Next cycle: out_valid=0, out_ctrl=0, in_ready=1.
- Reset: rst_n=0 at a clock edge gives state EMPTY, M=S=0 and stall_cnt=0. rst_n has priority over flush.
  - Outputs after reset: out_valid=0, out_data=0, out_ctrl=0, in_ready=1.
  - Reset mid-transfer discards both entries.
- out_ready=0 while EMPTY has no effect.
- in_valid while FULL is ignored; upstream must hold it.

Optional Feature:
- Macro: PIPE_STAGE_SKID_PERF_EN.
- When defined:
  - stall_cnt increments each cycle with out_valid & !out_ready & !flush.
  - Saturates at 16'hFFFF.
  - Cleared only by rst_n; flush does not clear it.
- When undefined: stall_cnt is tied to 16'h0000 and no counter logic is built.
- The port exists in both builds.

Test Plan:
- Reset then stream: rst_n=0 for 2 cycles, then in_valid=1 with data 0xA5A5/0x1234, ctrl=1, out_ready=1 held.
  - Next cycle: out_valid=1, out_data={0x1234,0xA5A5}, out_ctrl=1, in_ready=1.
  - Values 1..8 on lane 0 emerge in order, one per cycle.
- Backpressure fill: out_ready=0 and push 0x0001, 0x0002, 0x0003.
  - State reaches FULL and in_ready=0 after 2 accepts; 0x0003 is not accepted.
  - Set out_ready=1: outputs 0x0001, 0x0002, 0x0003 on consecutive cycles, no loss.
- Bubble masking: HALF state with ctrl=1, then dep with no acc.
  - Next cycle: out_valid=0 and out_ctrl=0, while out_data retains its last value.
- Flush priority: FULL state, flush=1 with in_valid=1 and out_ready=1.
  - Next cycle: out_valid=0, out_ctrl=0, in_ready=1; the flushed input never appears.
- Reset over flush: rst_n=0 and flush=1 together while HALF.
  - Next cycle: out_data=0, out_valid=0, stall_cnt=0.
- Perf counter, with PIPE_STAGE_SKID_PERF_EN: hold a valid entry with out_ready=0 for 10 cycles, giving stall_cnt=10.
  - flush leaves it at 10.
  - Forcing 70000 stall cycles saturates it at 0xFFFF.
  - Without the macro, stall_cnt=0 throughout.
